// File: rtl/floppy_arb_pkg.sv
// Shared definitions for the floppy read arbiter: FSM states, requester id,
// default WAIT timeout and the round-robin helpers.
package floppy_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    INT = 1'b0,
    EXT = 1'b1
  } req_id_t;

  localparam int DEFAULT_TIMEOUT = 255;

  // Winner for one IDLE cycle: a lone requester always wins, a tie goes to ptr.
  function automatic req_id_t arb_pick(input logic req_int, input logic req_ext,
                                       input req_id_t ptr);
    req_id_t id;
    if (req_int && req_ext) begin
      id = ptr;
    end else if (req_ext) begin
      id = EXT;
    end else begin
      id = INT;
    end
    return id;
  endfunction

  // The drive that is not 'id'.
  function automatic req_id_t other_id(input req_id_t id);
    return (id == INT) ? EXT : INT;
  endfunction

endpackage

// File: rtl/floppy_read_arbiter_if.sv
// Drive-side and image-memory-side signals of the floppy read arbiter.
// slave: the arbiter; master: whatever drives the requests and the memory.
interface floppy_read_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              reqInt;
  logic [ADDR_W-1:0] addrInt;
  logic              ackInt;
  logic              reqExt;
  logic [ADDR_W-1:0] addrExt;
  logic              ackExt;
  logic [7:0]        dskReadData;
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memAck;
  logic [7:0]        memData;
  logic              busy;
  logic              timeoutErr;

  modport slave (
    input  reqInt, addrInt, reqExt, addrExt, memAck, memData,
    output ackInt, ackExt, dskReadData, memReq, memAddr, busy, timeoutErr
  );

  modport master (
    output reqInt, addrInt, reqExt, addrExt, memAck, memData,
    input  ackInt, ackExt, dskReadData, memReq, memAddr, busy, timeoutErr
  );
endinterface

// File: rtl/floppy_arb_wdt.sv
// WAIT-state watchdog for the floppy read arbiter. Only instantiated when
// FLOPPY_ARB_TIMEOUT_EN is defined. 'expired' is high during the TIMEOUT-th
// consecutive cycle with 'run' high; 'clear' restarts the count.
module floppy_arb_wdt
  import floppy_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic _reset,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Count consecutive run cycles; clear has priority.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign expired = run && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/floppy_read_arbiter.sv
// Two-drive read arbiter in front of a shared disk-image memory.
// IDLE -> ISSUE -> WAIT -> DONE, round-robin on ties, one-cycle acks.
// Optional feature macro: FLOPPY_ARB_TIMEOUT_EN (WAIT-state abort after
// TIMEOUT cycles with data 8'hFF and a sticky timeoutErr).
module floppy_read_arbiter
  import floppy_arb_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 _reset,
  floppy_read_arbiter_if.slave bus
);
  arb_state_t        state;
  arb_state_t        state_nxt;
  req_id_t           ptr;
  req_id_t           winner;
  req_id_t           pick;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              ack_int;
  logic              ack_ext;
  logic [7:0]        dsk_read_data;
  logic              any_req;
  logic              issue_go;
  logic              complete;
  logic              expired;

  // Requests are only looked at in IDLE, so the winner of a just-acked
  // transfer cannot be re-granted from a stale req.
  always_comb begin
    any_req = bus.reqInt | bus.reqExt;
    pick    = arb_pick(bus.reqInt, bus.reqExt, ptr);
  end

  // Next-state decode; memAck only counts in WAIT.
  always_comb begin
    state_nxt = state;
    issue_go  = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ISSUE;
          issue_go  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.memAck || expired) begin
          state_nxt = DONE;
          complete  = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant latch, memory strobe, read data, acks and the round-robin pointer.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      ptr           <= INT;
      winner        <= INT;
      mem_addr      <= '0;
      mem_req       <= 1'b0;
      ack_int       <= 1'b0;
      ack_ext       <= 1'b0;
      dsk_read_data <= 8'h00;
    end else begin
      if (issue_go) begin
        winner   <= pick;
        mem_addr <= (pick == EXT) ? bus.addrExt : bus.addrInt;
      end
      mem_req <= issue_go;
      ack_int <= complete && (winner == INT);
      ack_ext <= complete && (winner == EXT);
      if (complete) begin
        dsk_read_data <= bus.memAck ? bus.memData : 8'hFF;
      end
      if (state == DONE) begin
        ptr <= other_id(winner);
      end
    end
  end

`ifdef FLOPPY_ARB_TIMEOUT_EN
  logic timeout_err;

  floppy_arb_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk    (clk),
    ._reset (_reset),
    .run    (state == WAIT),
    .clear  (state != WAIT),
    .expired(expired)
  );

  // Sticky abort flag: set when WAIT ends without memAck.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      timeout_err <= 1'b0;
    end else if (complete && !bus.memAck) begin
      timeout_err <= 1'b1;
    end else begin
      timeout_err <= timeout_err;
    end
  end

  assign bus.timeoutErr = timeout_err;
`else
  assign expired        = 1'b0;
  assign bus.timeoutErr = 1'b0;
`endif

  assign bus.memReq      = mem_req;
  assign bus.memAddr     = mem_addr;
  assign bus.ackInt      = ack_int;
  assign bus.ackExt      = ack_ext;
  assign bus.dskReadData = dsk_read_data;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_floppy_read_arbiter.sv
// Directed bench for floppy_read_arbiter: expected transfers are queued when
// a request is raised and checked when the memory strobe / ack appear.
module tb_floppy_read_arbiter;
  import floppy_arb_pkg::*;

  typedef struct packed {
    req_id_t     id;
    logic [21:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk;
  logic _reset;
  int   checks;
  int   fails;
  exp_t sb[$];

  floppy_read_arbiter_if #(.ADDR_W(22)) bus ();

  floppy_read_arbiter #(
    .ADDR_W (22),
    .TIMEOUT(255)
  ) dut (
    .clk   (clk),
    ._reset(_reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drop(input req_id_t id);
    if (id == INT) bus.reqInt = 1'b0;
    else           bus.reqExt = 1'b0;
  endtask

  // Serve the oldest queued transfer: check strobe/address, answer with the
  // queued byte after 'delay' extra WAIT cycles, then check the ack.
  task automatic serve(input int exp_lat, input int delay, input bit drop_in_wait,
                       input bit drop_on_ack);
    exp_t e;
    int   n;
    int   m;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (bus.memReq !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("memreq_seen", bus.memReq, 1);
    if (exp_lat >= 0) check("memreq_latency", n, exp_lat);
    check("memaddr", bus.memAddr, e.addr);
    @(negedge clk);
    check("memreq_one_cycle", bus.memReq, 0);
    if (drop_in_wait) drop(e.id);
    if (e.id == INT) bus.addrInt = ~e.addr;
    else             bus.addrExt = ~e.addr;
    repeat (delay) @(negedge clk);
    bus.memAck  = 1'b1;
    bus.memData = e.data;
    @(negedge clk);
    m = 1;
    bus.memAck  = 1'b0;
    bus.memData = 8'h00;
    while (bus.ackInt !== 1'b1 && bus.ackExt !== 1'b1 && m < 50) begin
      @(negedge clk);
      m++;
    end
    check("ack_latency", m, 1);
    check("ack_int", bus.ackInt, (e.id == INT));
    check("ack_ext", bus.ackExt, (e.id == EXT));
    check("read_data", bus.dskReadData, e.data);
    check("memaddr_held", bus.memAddr, e.addr);
    if (e.id == INT) bus.addrInt = e.addr;
    else             bus.addrExt = e.addr;
    if (drop_on_ack) drop(e.id);
    @(negedge clk);
    check("ack_one_cycle", bus.ackInt | bus.ackExt, 0);
  endtask

  initial begin
    int n;
    checks      = 0;
    fails       = 0;
    _reset      = 1'b0;
    bus.reqInt  = 1'b0;
    bus.reqExt  = 1'b0;
    bus.addrInt = 22'h0;
    bus.addrExt = 22'h0;
    bus.memAck  = 1'b0;
    bus.memData = 8'h00;

    // Reset state.
    @(negedge clk);
    check("rst_memreq", bus.memReq, 0);
    check("rst_memaddr", bus.memAddr, 0);
    check("rst_acks", {bus.ackInt, bus.ackExt}, 0);
    check("rst_data", bus.dskReadData, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_timeouterr", bus.timeoutErr, 0);

    // Stray memAck in IDLE is ignored.
    _reset = 1'b1;
    @(negedge clk);
    bus.memAck  = 1'b1;
    bus.memData = 8'h3C;
    @(negedge clk);
    bus.memAck  = 1'b0;
    bus.memData = 8'h00;
    @(negedge clk);
    check("idle_ack_data", bus.dskReadData, 0);
    check("idle_ack_busy", bus.busy, 0);
    check("idle_ack_acks", {bus.ackInt, bus.ackExt}, 0);

    // Single internal read, minimum latency.
    bus.reqInt  = 1'b1;
    bus.addrInt = 22'h000123;
    sb.push_back('{INT, 22'h000123, 8'hA5});
    serve(1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("single_no_regrant", bus.memReq, 0);
      check("single_idle", bus.busy, 0);
      check("data_hold", bus.dskReadData, 8'hA5);
    end

    // Both drives requesting out of reset: Int first, then Ext.
    _reset      = 1'b0;
    bus.reqInt  = 1'b1;
    bus.addrInt = 22'h0001F0;
    bus.reqExt  = 1'b1;
    bus.addrExt = 22'h3C0A55;
    @(negedge clk);
    _reset = 1'b1;
    sb.push_back('{INT, 22'h0001F0, 8'h5A});
    sb.push_back('{EXT, 22'h3C0A55, 8'hC3});
    serve(1, 1, 1'b0, 1'b1);
    serve(-1, 0, 1'b0, 1'b1);

    // Ext drops its request in WAIT; the transfer still completes once.
    bus.reqExt  = 1'b1;
    bus.addrExt = 22'h2ABCDE;
    sb.push_back('{EXT, 22'h2ABCDE, 8'h96});
    serve(1, 2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("dropped_no_memreq", bus.memReq, 0);
      check("dropped_idle", bus.busy, 0);
      @(negedge clk);
    end

    // Int held continuously, Ext requests once: Int, Ext, Int.
    bus.reqInt  = 1'b1;
    bus.addrInt = 22'h012345;
    @(negedge clk);
    bus.reqExt  = 1'b1;
    bus.addrExt = 22'h1FEDCB;
    sb.push_back('{INT, 22'h012345, 8'h11});
    sb.push_back('{EXT, 22'h1FEDCB, 8'h22});
    sb.push_back('{INT, 22'h012345, 8'h33});
    serve(0, 0, 1'b0, 1'b0);
    serve(-1, 1, 1'b0, 1'b1);
    serve(-1, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("rr_done_idle", bus.busy, 0);

    // Reset in WAIT, memAck after release: no ack, cleared data.
    bus.reqInt  = 1'b1;
    bus.addrInt = 22'h00ABCD;
    n = 0;
    while (bus.memReq !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rstwait_memreq_seen", bus.memReq, 1);
    @(negedge clk);
    check("rstwait_busy_before", bus.busy, 1);
    _reset = 1'b0;
    #1;
    check("rstwait_async_busy", bus.busy, 0);
    check("rstwait_async_addr", bus.memAddr, 0);
    bus.reqInt = 1'b0;
    @(negedge clk);
    _reset = 1'b1;
    @(negedge clk);
    bus.memAck  = 1'b1;
    bus.memData = 8'h77;
    @(negedge clk);
    bus.memAck  = 1'b0;
    bus.memData = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check("rstwait_no_ack", {bus.ackInt, bus.ackExt}, 0);
      check("rstwait_data", bus.dskReadData, 0);
      check("rstwait_busy", bus.busy, 0);
      @(negedge clk);
    end

`ifdef FLOPPY_ARB_TIMEOUT_EN
    // memAck never comes: abort after 255 WAIT cycles.
    bus.reqExt  = 1'b1;
    bus.addrExt = 22'h000777;
    n = 0;
    while (bus.memReq !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_memreq_seen", bus.memReq, 1);
    n = 0;
    while (bus.ackExt !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("to_ack_cycles", n, 256);
    check("to_data", bus.dskReadData, 8'hFF);
    check("to_err", bus.timeoutErr, 1);
    check("to_ack_int", bus.ackInt, 0);
    bus.reqExt = 1'b0;
    repeat (3) @(negedge clk);
    check("to_err_sticky", bus.timeoutErr, 1);
    check("to_idle", bus.busy, 0);
`else
    check("no_timeout_err", bus.timeoutErr, 0);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/floppy_read_arbiter.md
FLOPPY_READ_ARBITER -- requirements
Module: floppy_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 22: width of the disk-image byte address.
REQ-002 Parameter TIMEOUT, default 255: maximum number of WAIT cycles allowed before an abort (used only with the macro).
REQ-003 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 Port _reset, input, 1: asynchronous, active-low reset.
REQ-005 Port reqInt, input, 1: internal-drive read request; held high with addrInt stable until ackInt.
REQ-006 Port addrInt, input, ADDR_W: internal-drive byte address.
REQ-007 Port ackInt, output, 1: one-cycle pulse; dskReadData is valid for the internal drive.
REQ-008 Port reqExt, input, 1: external-drive read request; same rules as reqInt.
REQ-009 Port addrExt, input, ADDR_W: external-drive byte address.
REQ-010 Port ackExt, output, 1: one-cycle pulse; dskReadData is valid for the external drive.
REQ-011 Port dskReadData, output, 8: registered read byte, shared by both drives.
REQ-012 Port memReq, output, 1: one-cycle read strobe to the image memory.
REQ-013 Port memAddr, output, ADDR_W: registered address of the granted requester.
REQ-014 Port memAck, input, 1: memory data valid on memData.
REQ-015 Port memData, input, 8: memory read byte.
REQ-016 Port busy, output, 1: high whenever the state is not IDLE.
REQ-017 Port timeoutErr, output, 1: sticky abort flag.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-019 IDLE: if any req is high, the arbiter SHALL latch the winner id and address into memAddr, then go to ISSUE; with no request it SHALL stay in IDLE.
REQ-020 ISSUE: the arbiter SHALL assert memReq for exactly one cycle, then go to WAIT.
REQ-021 WAIT: on memAck, dskReadData SHALL be loaded with memData and the FSM SHALL go to DONE; memAck outside WAIT SHALL be ignored.
REQ-022 DONE: the arbiter SHALL pulse the winner's ack for one cycle, toggle the priority pointer to the other drive, and return to IDLE.
REQ-023 Latency SHALL be: req high in IDLE at cycle T, memReq at T+1, memAck no earlier than T+2, ack at the cycle after memAck (minimum T+3).
REQ-024 Single requester: it SHALL be granted regardless of the pointer.
REQ-025 Both requesters high in IDLE: the pointer SHALL select the winner (round-robin); two back-to-back winners SHALL always alternate.
REQ-026 A requester acked in DONE SHALL NOT be re-evaluated until IDLE, so that a req dropped in the cycle after ack is never re-granted.
REQ-027 A req withdrawn mid-transaction SHALL NOT abort the transaction; the ack is still pulsed.
REQ-028 A change on addrInt or addrExt after the grant SHALL NOT affect memAddr.
REQ-029 dskReadData SHALL hold its last value between captures.
REQ-030 ackInt and ackExt SHALL never be high in the same cycle.

Reset
REQ-031 With _reset low, asynchronously: state IDLE, pointer Int, memReq 0, memAddr 0, ackInt/ackExt 0, dskReadData 0, busy 0, timeoutErr 0, timeout counter 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction without an ack; a memAck arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-033 Macro FLOPPY_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT. When it reaches TIMEOUT without memAck, the FSM SHALL go to DONE, load dskReadData with 8'hFF, set timeoutErr, and still pulse the ack.
REQ-034 Macro FLOPPY_ARB_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely and timeoutErr SHALL be tied to 0.

Structure
REQ-035 Shared package floppy_arb_pkg SHALL hold the FSM state enum, the requester-id type (INT=0, EXT=1) and the default TIMEOUT constant.
REQ-036 The timeout counter SHALL be one sub-module, floppy_arb_wdt (inputs: run, clear; output: expired), instantiated only when FLOPPY_ARB_TIMEOUT_EN is defined.

Verification
REQ-037 reqInt=1, addrInt=22'h000123, memAck 1 cycle after memReq with memData=8'hA5 -> memAddr=22'h000123, ackInt at T+3, dskReadData=8'hA5, ackExt stays 0.
REQ-038 reqInt and reqExt both high from reset -> Int served first, then Ext; memAddr sequence addrInt, addrExt; acks alternate.
REQ-039 reqExt dropped in WAIT, memAck arrives -> ackExt still pulses; the FSM returns to IDLE; no second memReq.
REQ-040 _reset asserted in WAIT, memAck pulsed after release -> no ack, dskReadData=0, busy=0.
REQ-041 With FLOPPY_ARB_TIMEOUT_EN and TIMEOUT=255, memAck never asserted -> ack at 255 WAIT cycles + 1, dskReadData=8'hFF, timeoutErr=1 and sticky.
REQ-042 reqInt held high continuously while reqExt pulses once -> the grant order is Int, Ext, Int.
